// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard and its operand checkers.
package hazard_pkg;

    // Widest Tnew/Tuse the scoreboard storage can hold; narrower fields are zero-extended.
    localparam int TNEW_MAX_W = 4;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [4:0]            addr;
        logic [TNEW_MAX_W-1:0] tnew;
    } sb_entry_t;

    // Width of a forwarding select: 0 = register file, 1..nstage = stage index + 1.
    function automatic int sel_width(input int nstage);
        return (nstage < 1) ? 1 : $clog2(nstage + 1);
    endfunction

    // Tnew counts down once per stage and parks at zero until the entry retires.
    function automatic logic [TNEW_MAX_W-1:0] tnew_dec(input logic [TNEW_MAX_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_MAX_W'(1);
    endfunction

endpackage

// File: rtl/hazard_port_check.sv
// Youngest-match search of the scoreboard for one source operand.
module hazard_port_check
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3
) (
    input  sb_entry_t                      ent_i [NSTAGE],
    input  logic [4:0]                     reg_i,
    input  logic [TNEW_MAX_W-1:0]          tuse_i,
    output logic                           hazard_o,
    output logic [sel_width(NSTAGE)-1:0]   sel_o
);

    localparam int SEL_W = sel_width(NSTAGE);

    // Walk oldest to youngest so the lowest-index match overrides older ones.
    always_comb begin
        hazard_o = 1'b0;
        sel_o    = SEL_W'(FWD_RF);
        if (reg_i != 5'd0) begin
            for (int i = NSTAGE - 1; i >= 0; i--) begin
                if (ent_i[i].valid && (ent_i[i].addr == reg_i)) begin
                    hazard_o = (ent_i[i].tnew > tuse_i);
                    sel_o    = (ent_i[i].tnew == '0) ? SEL_W'(i + 1) : SEL_W'(FWD_RF);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard unit: tracks in-flight GPR writes, MDU busy time and
// eret drain, and produces the D-stage stall plus per-operand forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE     = 3,
    parameter int TNEW_W     = 2,
    parameter int MULT_CYC   = 5,
    parameter int DIV_CYC    = 10,
    parameter int ERET_STALL = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          d_valid,
    input  logic [4:0]                    d_rs,
    input  logic [4:0]                    d_rt,
    input  logic [TNEW_W-1:0]             d_tuse_rs,
    input  logic [TNEW_W-1:0]             d_tuse_rt,
    input  logic                          d_wr_en,
    input  logic [4:0]                    d_wr_addr,
    input  logic [TNEW_W-1:0]             d_tnew,
    input  logic                          d_md_start,
    input  logic                          d_md_is_div,
    input  logic                          d_md_access,
    input  logic                          d_eret,
    output logic                          stall,
    output logic [sel_width(NSTAGE)-1:0]  fwd_rs_sel,
    output logic [sel_width(NSTAGE)-1:0]  fwd_rt_sel,
    output logic                          md_busy,
    output logic                          md_start_e
);

    localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int MD_W   = $clog2(MD_MAX + 1);
    localparam int ER_W   = (ERET_STALL < 1) ? 1 : $clog2(ERET_STALL + 1);

    sb_entry_t         ent_q [NSTAGE];
    sb_entry_t         ent_d [NSTAGE];
    logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
    logic              md_start_e_q, md_start_e_d;
    logic [ER_W-1:0]   eret_cnt_q, eret_cnt_d;

    logic hz_rs, hz_rt;
    logic stall_md, stall_eret;
    logic md_accept;

    hazard_port_check #(.NSTAGE(NSTAGE)) u_rs_check (
        .ent_i    (ent_q),
        .reg_i    (d_rs),
        .tuse_i   (TNEW_MAX_W'(d_tuse_rs)),
        .hazard_o (hz_rs),
        .sel_o    (fwd_rs_sel)
    );

    hazard_port_check #(.NSTAGE(NSTAGE)) u_rt_check (
        .ent_i    (ent_q),
        .reg_i    (d_rt),
        .tuse_i   (TNEW_MAX_W'(d_tuse_rt)),
        .hazard_o (hz_rt),
        .sel_o    (fwd_rt_sel)
    );

    // Combine all stall sources; a flush redirect always lets D go.
    always_comb begin
        md_busy    = (md_cnt_q != '0);
        md_start_e = md_start_e_q;
        stall_md   = (d_md_access | d_md_start) & md_busy;
        stall_eret = d_eret & (eret_cnt_q < ER_W'(ERET_STALL));
        stall      = d_valid & ~flush & (hz_rs | hz_rt | stall_md | stall_eret);
        md_accept  = d_valid & d_md_start & ~stall & ~flush;
    end

    // Shift the scoreboard one stage, inserting the D writer or a bubble at E.
    always_comb begin
        ent_d[0].valid = d_valid & d_wr_en & (d_wr_addr != 5'd0) & ~stall;
        ent_d[0].addr  = d_wr_addr;
        ent_d[0].tnew  = TNEW_MAX_W'(d_tnew);
        for (int i = 1; i < NSTAGE; i++) begin
            ent_d[i]      = ent_q[i-1];
            ent_d[i].tnew = tnew_dec(ent_q[i-1].tnew);
        end
        if (flush) begin
            for (int i = 0; i < NSTAGE; i++) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    // MDU busy countdown; loads when the MDU op leaves D, otherwise counts to zero.
    always_comb begin
        md_start_e_d = md_accept;
        if (md_accept) begin
            md_cnt_d = d_md_is_div ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end else begin
            md_cnt_d = '0;
        end
    end

    // Eret hold counter: counts held cycles, clears as soon as D advances or is flushed.
    always_comb begin
        if (flush) begin
            eret_cnt_d = '0;
        end else if (d_valid & d_eret & stall) begin
            eret_cnt_d = (eret_cnt_q == ER_W'(ERET_STALL)) ? eret_cnt_q : eret_cnt_q + ER_W'(1);
        end else begin
            eret_cnt_d = '0;
        end
    end

    // Scoreboard registers; only the valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSTAGE; i++) begin
            ent_q[i] <= ent_d[i];
            if (reset) begin
                ent_q[i].valid <= 1'b0;
            end
        end
    end

    // MDU and eret control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q     <= '0;
            md_start_e_q <= 1'b0;
            eret_cnt_q   <= '0;
        end else begin
            md_cnt_q     <= md_cnt_d;
            md_start_e_q <= md_start_e_d;
            eret_cnt_q   <= eret_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (default parameters: NSTAGE 3, MULT 5, DIV 10, ERET 1).
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset, flush, d_valid;
    logic [4:0] d_rs, d_rt, d_wr_addr;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_wr_en, d_md_start, d_md_is_div, d_md_access, d_eret;
    logic       stall, md_busy, md_start_e;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .d_valid     (d_valid),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_wr_en     (d_wr_en),
        .d_wr_addr   (d_wr_addr),
        .d_tnew      (d_tnew),
        .d_md_start  (d_md_start),
        .d_md_is_div (d_md_is_div),
        .d_md_access (d_md_access),
        .d_eret      (d_eret),
        .stall       (stall),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel),
        .md_busy     (md_busy),
        .md_start_e  (md_start_e)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        flush       = 1'b0;
        d_valid     = 1'b0;
        d_rs        = 5'd0;
        d_rt        = 5'd0;
        d_tuse_rs   = 2'd0;
        d_tuse_rt   = 2'd0;
        d_wr_en     = 1'b0;
        d_wr_addr   = 5'd0;
        d_tnew      = 2'd0;
        d_md_start  = 1'b0;
        d_md_is_div = 1'b0;
        d_md_access = 1'b0;
        d_eret      = 1'b0;
    endtask

    task automatic put(input logic [4:0] rs, input logic [1:0] tur,
                       input logic [4:0] rt, input logic [1:0] tut,
                       input logic we, input logic [4:0] wa, input logic [1:0] tn);
        idle();
        d_valid   = 1'b1;
        d_rs      = rs;
        d_tuse_rs = tur;
        d_rt      = rt;
        d_tuse_rt = tut;
        d_wr_en   = we;
        d_wr_addr = wa;
        d_tnew    = tn;
    endtask

    task automatic drain();
        idle();
        repeat (12) tick();
    endtask

    task automatic test_reset();
        settle();
        checks++; if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy, md_start_e} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b required 0000000",
                               {stall, fwd_rs_sel, fwd_rt_sel, md_busy, md_start_e});
        end
        reset = 1'b0;
        put(0, 0, 0, 0, 1'b1, 5'd8, 2'd2);
        tick();
        put(5'd8, 2'd0, 0, 0, 1'b0, 0, 0);
        settle();
        checks++; if (stall !== 1'b1) begin
            errors++; $display("FAIL reset_pre_stall: stall=%b required 1", stall);
        end
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        put(5'd8, 2'd0, 5'd8, 2'd0, 1'b0, 0, 0);
        settle();
        checks++; if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b0) begin
            errors++; $display("FAIL reset_clears_entries: got %b required 00000",
                               {stall, fwd_rs_sel, fwd_rt_sel});
        end
        tick();
    endtask

    task automatic test_load_use();
        drain();
        put(0, 0, 0, 0, 1'b1, 5'd8, 2'd2);
        settle();
        checks++; if (stall !== 1'b0) begin
            errors++; $display("FAIL lw_issue: stall=%b required 0", stall);
        end
        tick();
        put(5'd8, 2'd1, 0, 0, 1'b1, 5'd11, 2'd1);
        settle();
        checks++; if ({stall, fwd_rs_sel} !== 3'b1_00) begin
            errors++; $display("FAIL lw_use_stall: stall/sel=%b required 100", {stall, fwd_rs_sel});
        end
        tick();
        settle();
        checks++; if ({stall, fwd_rs_sel} !== 3'b0_00) begin
            errors++; $display("FAIL lw_use_release: stall/sel=%b required 000", {stall, fwd_rs_sel});
        end
        tick();
        put(5'd8, 2'd0, 0, 0, 1'b0, 0, 0);
        settle();
        checks++; if ({stall, fwd_rs_sel} !== 3'b0_11) begin
            errors++; $display("FAIL lw_fwd_w: stall/sel=%b required 011", {stall, fwd_rs_sel});
        end
        tick();
    endtask

    task automatic test_branch();
        drain();
        put(0, 0, 0, 0, 1'b1, 5'd9, 2'd1);
        tick();
        put(5'd9, 2'd0, 0, 0, 1'b0, 0, 0);
        settle();
        checks++; if (stall !== 1'b1) begin
            errors++; $display("FAIL beq_stall: stall=%b required 1", stall);
        end
        tick();
        settle();
        checks++; if ({stall, fwd_rs_sel} !== 3'b0_10) begin
            errors++; $display("FAIL beq_fwd_m: stall/sel=%b required 010", {stall, fwd_rs_sel});
        end
        tick();
        drain();
        put(0, 0, 0, 0, 1'b1, 5'd9, 2'd1);
        tick();
        put(0, 0, 0, 0, 1'b0, 0, 0);
        tick();
        put(5'd9, 2'd0, 5'd9, 2'd0, 1'b0, 0, 0);
        settle();
        checks++; if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b0_10_10) begin
            errors++; $display("FAIL beq_nop_fwd: stall/rs/rt=%b required 01010",
                               {stall, fwd_rs_sel, fwd_rt_sel});
        end
        tick();
        settle();
        checks++; if ({stall, fwd_rs_sel} !== 3'b0_11) begin
            errors++; $display("FAIL tnew_floor_w: stall/sel=%b required 011", {stall, fwd_rs_sel});
        end
        tick();
    endtask

    task automatic test_youngest();
        drain();
        put(0, 0, 0, 0, 1'b1, 5'd10, 2'd0);
        tick();
        put(0, 0, 0, 0, 1'b1, 5'd10, 2'd0);
        tick();
        put(0, 0, 5'd10, 2'd1, 1'b0, 0, 0);
        settle();
        checks++; if ({stall, fwd_rt_sel} !== 3'b0_01) begin
            errors++; $display("FAIL youngest_both_ready: stall/sel=%b required 001", {stall, fwd_rt_sel});
        end
        drain();
        put(0, 0, 0, 0, 1'b1, 5'd10, 2'd3);
        tick();
        put(0, 0, 0, 0, 1'b1, 5'd10, 2'd0);
        tick();
        put(0, 0, 5'd10, 2'd0, 1'b0, 0, 0);
        settle();
        checks++; if ({stall, fwd_rt_sel} !== 3'b0_01) begin
            errors++; $display("FAIL youngest_masks_older: stall/sel=%b required 001", {stall, fwd_rt_sel});
        end
        tick();
    endtask

    task automatic test_mdu();
        drain();
        put(0, 0, 0, 0, 1'b0, 0, 0);
        d_md_start  = 1'b1;
        d_md_is_div = 1'b1;
        settle();
        checks++; if ({stall, md_busy} !== 2'b00) begin
            errors++; $display("FAIL div_issue: stall/busy=%b required 00", {stall, md_busy});
        end
        tick();
        put(0, 0, 0, 0, 1'b1, 5'd12, 2'd1);
        d_md_access = 1'b1;
        settle();
        checks++; if (md_start_e !== 1'b1) begin
            errors++; $display("FAIL div_start_e: md_start_e=%b required 1", md_start_e);
        end
        for (int k = 0; k < 10; k++) begin
            settle();
            checks++; if ({stall, md_busy} !== 2'b11) begin
                errors++; $display("FAIL mflo_wait_%0d: stall/busy=%b required 11", k, {stall, md_busy});
            end
            if (k == 1) begin
                checks++; if (md_start_e !== 1'b0) begin
                    errors++; $display("FAIL div_start_e_pulse: md_start_e=%b required 0", md_start_e);
                end
            end
            tick();
        end
        settle();
        checks++; if ({stall, md_busy} !== 2'b00) begin
            errors++; $display("FAIL mflo_release: stall/busy=%b required 00", {stall, md_busy});
        end
        tick();
        put(0, 0, 0, 0, 1'b0, 0, 0);
        d_md_start = 1'b1;
        settle();
        checks++; if (stall !== 1'b0) begin
            errors++; $display("FAIL mult_issue: stall=%b required 0", stall);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++; if ({stall, md_busy} !== 2'b11) begin
                errors++; $display("FAIL mult_busy_%0d: stall/busy=%b required 11", k, {stall, md_busy});
            end
            tick();
        end
        settle();
        checks++; if ({stall, md_busy} !== 2'b00) begin
            errors++; $display("FAIL mult_release: stall/busy=%b required 00", {stall, md_busy});
        end
        tick();
        idle();
    endtask

    task automatic test_eret();
        drain();
        for (int n = 0; n < 2; n++) begin
            put(0, 0, 0, 0, 1'b0, 0, 0);
            d_eret = 1'b1;
            settle();
            checks++; if (stall !== 1'b1) begin
                errors++; $display("FAIL eret_hold_%0d: stall=%b required 1", n, stall);
            end
            tick();
            settle();
            checks++; if (stall !== 1'b0) begin
                errors++; $display("FAIL eret_release_%0d: stall=%b required 0", n, stall);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid_div();
        drain();
        put(0, 0, 0, 0, 1'b0, 0, 0);
        d_md_start  = 1'b1;
        d_md_is_div = 1'b1;
        tick();
        idle();
        repeat (2) tick();
        settle();
        checks++; if (md_busy !== 1'b1) begin
            errors++; $display("FAIL div_running: md_busy=%b required 1", md_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        checks++; if ({md_busy, md_start_e} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_div: busy/start_e=%b required 00", {md_busy, md_start_e});
        end
    endtask

    task automatic test_flush();
        drain();
        put(0, 0, 0, 0, 1'b1, 5'd8, 2'd2);
        tick();
        put(5'd8, 2'd1, 0, 0, 1'b1, 5'd11, 2'd1);
        settle();
        checks++; if (stall !== 1'b1) begin
            errors++; $display("FAIL flush_pre_stall: stall=%b required 1", stall);
        end
        flush = 1'b1;
        settle();
        checks++; if (stall !== 1'b0) begin
            errors++; $display("FAIL flush_wins: stall=%b required 0", stall);
        end
        tick();
        put(5'd8, 2'd0, 5'd11, 2'd0, 1'b0, 0, 0);
        settle();
        checks++; if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b0) begin
            errors++; $display("FAIL flush_empties: stall/rs/rt=%b required 00000",
                               {stall, fwd_rs_sel, fwd_rt_sel});
        end
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) tick();
        test_reset();
        test_load_use();
        test_branch();
        test_youngest();
        test_mdu();
        test_eret();
        test_reset_mid_div();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
